piso_stream: RTL and testbench
==============================

Name: piso_stream

Overview:
- Parametrised parallel-in/serial-out shifter with a valid/ready load handshake, programmable bit period, selectable bit order and completion pulse.
- Next generation of our fixed-width free-running PISO. Feeds driver-facing serial links such as the stepper driver's configuration port, one word per transaction.
- Sits between the register/command logic (parallel side) and the serial pin logic.

Parameters:
- SIZE, 8, word width in bits; legal range 2..64.
- CLK_DIV, 1, clk_in cycles per serial bit; legal range 1..256.
- LSB_FIRST, 0, 0 = MSB shifted first, 1 = LSB shifted first.
- IDLE_LEVEL, 1'b0, value driven on r_data_out when no word is shifting.

Ports:
- clk_in  input  1  system clock, all logic on rising edge
- reset_in  input  1  synchronous, active-high reset
- data_in  input  SIZE  parallel word, sampled only on handshake
- valid_in  input  1  word on data_in is valid
- ready_out  output  1  block can accept a word
- r_data_out  output  1  registered serial output
- shift_strobe_out  output  1  one-cycle pulse on the last cycle of each bit period (sample point)
- busy_out  output  1  high while in SHIFT or DONE
- done_out  output  1  one-cycle pulse after the final bit

Behaviour:
- Synchronous, active-high reset: state IDLE, ready_out=1, busy_out=0, done_out=0, shift_strobe_out=0, r_data_out=IDLE_LEVEL. Shift, bit and divider counters are cleared.
- States: IDLE, SHIFT, DONE.
- IDLE: ready_out=1, r_data_out=IDLE_LEVEL.
- Handshake in cycle N (valid_in & ready_out): latch data_in and go to SHIFT. Bit counter=0, divider=0, ready_out=0 from N+1.
- SHIFT: bit k (k=0..SIZE-1) drives r_data_out during cycles N+1+k*CLK_DIV .. N+(k+1)*CLK_DIV.
  - Bit k is data_in[SIZE-1-k] when LSB_FIRST=0, data_in[k] when LSB_FIRST=1.
- shift_strobe_out is high in cycle N+(k+1)*CLK_DIV for every k. With CLK_DIV=1 it is high every SHIFT cycle.
- After the strobe of bit SIZE-1, go to DONE.
- DONE (cycle N+1+SIZE*CLK_DIV): done_out=1, r_data_out=IDLE_LEVEL, ready_out=0. Next cycle IDLE.
- Maximum throughput is one word per SIZE*CLK_DIV+2 cycles.
- valid_in while ready_out=0 is ignored; no queueing. Changes to data_in after the handshake have no effect.
- Reset asserted mid-SHIFT or in DONE: the next cycle shows reset values. done_out is never pulsed for an aborted word.
- Counter widths: bit counter $clog2(SIZE+1), divider $clog2(CLK_DIV+1), no wrap beyond terminal count. The CLK_DIV=1 divider is degenerate and must still synthesise.
- All outputs are registered; no combinational path from inputs to outputs except ready_out, which is registered state-derived.

Optional Feature:
- Macro: PISO_STREAM_CAPTURE_EN.
- When defined, adds ports serial_in (input, 1) and r_capture_out (output, SIZE) for full-duplex operation.
- serial_in is sampled on every shift_strobe_out cycle into a capture register, filled in the same bit order as transmit. Bit k goes to position SIZE-1-k for MSB-first, position k for LSB-first.
- r_capture_out updates in the DONE cycle and holds until the next DONE.
- Reset value of r_capture_out is 0. An aborted word leaves r_capture_out unchanged.
- When undefined, the ports and capture logic are absent and the behaviour above is otherwise identical.

Test Plan:
- SIZE=8, CLK_DIV=1, LSB_FIRST=0, data_in=8'hAC, handshake cycle N -> r_data_out 1,0,1,0,1,1,0,0 in N+1..N+8; done_out=1 only at N+9; ready_out=1 at N+10.
- Same with LSB_FIRST=1 -> r_data_out 0,0,1,1,0,1,0,1 in N+1..N+8.
- CLK_DIV=3, data_in=8'hAC -> each bit held 3 cycles; shift_strobe_out at N+3, N+6, ... N+24 (8 pulses); done_out at N+25.
- Reset asserted for 1 cycle after bit 3 is driven -> next cycle r_data_out=IDLE_LEVEL, ready_out=1, busy_out=0; no done_out pulse. A following 8'h55 transfer is correct.
- valid_in held high with data_in toggling 8'hFF/8'h00 during SHIFT of 8'hAC -> output stream still 8'hAC; next word is accepted only at N+10.
- PISO_STREAM_CAPTURE_EN defined, serial_in tied to r_data_out, data_in=8'hAC, both bit orders -> r_capture_out=8'hAC from the DONE cycle onward.

Source files
------------

// File: rtl/piso_stream.sv
// piso_stream: parallel-in/serial-out shifter with a valid/ready load
// handshake, programmable bit period (CLK_DIV), selectable bit order and a
// one-cycle completion pulse.
//
// Optional build macro: PISO_STREAM_CAPTURE_EN
//   Adds serial_in / r_capture_out for full-duplex use. serial_in is sampled
//   at every bit sample point and the assembled word is published in the
//   DONE cycle.

module piso_stream #(
    parameter int   SIZE       = 8,     // word width, 2..64
    parameter int   CLK_DIV    = 1,     // clk_in cycles per serial bit, 1..256
    parameter int   LSB_FIRST  = 0,     // 0: MSB first, 1: LSB first
    parameter logic IDLE_LEVEL = 1'b0   // line level when no word is shifting
) (
    input  logic            clk_in,
    input  logic            reset_in,
    input  logic [SIZE-1:0] data_in,
    input  logic            valid_in,
    output logic            ready_out,
    output logic            r_data_out,
    output logic            shift_strobe_out,
    output logic            busy_out,
    output logic            done_out
`ifdef PISO_STREAM_CAPTURE_EN
    ,
    input  logic            serial_in,
    output logic [SIZE-1:0] r_capture_out
`endif
);

    localparam int BIT_W = $clog2(SIZE + 1);
    localparam int DIV_W = $clog2(CLK_DIV + 1);

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SIZE - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    // With CLK_DIV=1 every bit period is a single cycle, so each freshly
    // loaded bit is also its own sample point.
    localparam logic STROBE_ON_LOAD = (CLK_DIV == 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state;
    logic [SIZE-1:0]  shreg;
    logic [BIT_W-1:0] bit_cnt;
    logic [DIV_W-1:0] div_cnt;

    // Next bit to transmit, taken from the end selected by the bit order.
    function automatic logic first_bit(input logic [SIZE-1:0] word);
        if (LSB_FIRST != 0) return word[0];
        else                return word[SIZE-1];
    endfunction

    // Word with its transmitted bit removed, next bit moved to the exit end.
    function automatic logic [SIZE-1:0] drop_bit(input logic [SIZE-1:0] word);
        if (LSB_FIRST != 0) return word >> 1;
        else                return word << 1;
    endfunction

    // ready/busy are decoded straight from the state register, so they carry
    // no combinational path from any input.
    assign ready_out = (state == S_IDLE);
    assign busy_out  = (state != S_IDLE);

    // Control FSM, bit/divider counters and the registered serial outputs.
    always_ff @(posedge clk_in) begin
        // NOTE: all state here uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (reset_in) begin
            state            <= S_IDLE;
            shreg            <= '0;
            bit_cnt          <= '0;
            div_cnt          <= '0;
            r_data_out       <= IDLE_LEVEL;
            shift_strobe_out <= 1'b0;
            done_out         <= 1'b0;
        end else begin
            shift_strobe_out <= 1'b0;
            done_out         <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (valid_in) begin
                        state            <= S_SHIFT;
                        r_data_out       <= first_bit(data_in);
                        shreg            <= drop_bit(data_in);
                        bit_cnt          <= '0;
                        div_cnt          <= '0;
                        shift_strobe_out <= STROBE_ON_LOAD;
                    end
                end
                S_SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            state      <= S_DONE;
                            r_data_out <= IDLE_LEVEL;
                            done_out   <= 1'b1;
                        end else begin
                            bit_cnt          <= bit_cnt + BIT_W'(1);
                            r_data_out       <= first_bit(shreg);
                            shreg            <= drop_bit(shreg);
                            shift_strobe_out <= STROBE_ON_LOAD;
                        end
                    end else begin
                        div_cnt          <= div_cnt + DIV_W'(1);
                        shift_strobe_out <= ((div_cnt + DIV_W'(1)) == DIV_LAST);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef PISO_STREAM_CAPTURE_EN
    logic [SIZE-1:0] cap_shreg;
    logic [SIZE-1:0] cap_next;

    // Capture shift register with serial_in inserted in transmit bit order.
    always_comb begin
        // NOTE: a default assignment first keeps this block free of latches.
        cap_next = cap_shreg;
        if (LSB_FIRST != 0) cap_next = {serial_in, cap_shreg[SIZE-1:1]};
        else                cap_next = {cap_shreg[SIZE-2:0], serial_in};
    end

    // Sample serial_in at each sample point; publish the word on the last one.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            cap_shreg     <= '0;
            r_capture_out <= '0;
        end else if (shift_strobe_out) begin
            cap_shreg <= cap_next;
            if ((state == S_SHIFT) && (bit_cnt == BIT_LAST))
                r_capture_out <= cap_next;
        end
    end
`endif

endmodule

// File: tb/tb_piso_stream.sv
// Directed self-checking bench for piso_stream. Three instances cover
// MSB-first/CLK_DIV=1, LSB-first/CLK_DIV=1 and MSB-first/CLK_DIV=3.
// Capture checks are compiled in when PISO_STREAM_CAPTURE_EN is defined.

module tb_piso_stream;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic       reset_in;
    logic       valid_a;
    logic       valid_d;
    logic [7:0] data_in;

    logic m_ready, m_data, m_strobe, m_busy, m_done;
    logic l_ready, l_data, l_strobe, l_busy, l_done;
    logic d_ready, d_data, d_strobe, d_busy, d_done;
`ifdef PISO_STREAM_CAPTURE_EN
    logic [7:0] m_cap, l_cap, d_cap;
`endif

    int checks = 0;
    int errors = 0;

    piso_stream #(.SIZE(8), .CLK_DIV(1), .LSB_FIRST(0), .IDLE_LEVEL(1'b0)) dut_msb (
        .clk_in(clk_in), .reset_in(reset_in), .data_in(data_in), .valid_in(valid_a),
        .ready_out(m_ready), .r_data_out(m_data), .shift_strobe_out(m_strobe),
        .busy_out(m_busy), .done_out(m_done)
`ifdef PISO_STREAM_CAPTURE_EN
        , .serial_in(m_data), .r_capture_out(m_cap)
`endif
    );

    piso_stream #(.SIZE(8), .CLK_DIV(1), .LSB_FIRST(1), .IDLE_LEVEL(1'b0)) dut_lsb (
        .clk_in(clk_in), .reset_in(reset_in), .data_in(data_in), .valid_in(valid_a),
        .ready_out(l_ready), .r_data_out(l_data), .shift_strobe_out(l_strobe),
        .busy_out(l_busy), .done_out(l_done)
`ifdef PISO_STREAM_CAPTURE_EN
        , .serial_in(l_data), .r_capture_out(l_cap)
`endif
    );

    piso_stream #(.SIZE(8), .CLK_DIV(3), .LSB_FIRST(0), .IDLE_LEVEL(1'b0)) dut_div3 (
        .clk_in(clk_in), .reset_in(reset_in), .data_in(data_in), .valid_in(valid_d),
        .ready_out(d_ready), .r_data_out(d_data), .shift_strobe_out(d_strobe),
        .busy_out(d_busy), .done_out(d_done)
`ifdef PISO_STREAM_CAPTURE_EN
        , .serial_in(d_data), .r_capture_out(d_cap)
`endif
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        logic [7:0] seq_msb_ac;
        logic [7:0] seq_lsb_ac;
        logic [7:0] seq_msb_55;
        logic [7:0] seq_lsb_55;
        logic [7:0] seq_msb_c3;
        int         strobes;

        // Streams written in transmit order: leftmost bit goes out first.
        seq_msb_ac = 8'b1010_1100;
        seq_lsb_ac = 8'b0011_0101;
        seq_msb_55 = 8'b0101_0101;
        seq_lsb_55 = 8'b1010_1010;
        seq_msb_c3 = 8'b1100_0011;

        reset_in = 1'b1;
        valid_a  = 1'b0;
        valid_d  = 1'b0;
        data_in  = 8'h00;

        // Reset state
        tick();
        tick();
        check("rst_ready",  m_ready,  1'b1);
        check("rst_busy",   m_busy,   1'b0);
        check("rst_done",   m_done,   1'b0);
        check("rst_strobe", m_strobe, 1'b0);
        check("rst_data",   m_data,   1'b0);
        check("rst_ready_div3", d_ready, 1'b1);
        reset_in = 1'b0;
        tick();

        // 8'hAC, CLK_DIV=1, both bit orders; handshake in this cycle (N)
        data_in = 8'hAC;
        valid_a = 1'b1;
        tick();                                 // N+1
        valid_a = 1'b0;
        data_in = 8'h00;
        for (int k = 0; k < 8; k++) begin
            check("ac_msb_bit",    m_data,   seq_msb_ac[7-k]);
            check("ac_lsb_bit",    l_data,   seq_lsb_ac[7-k]);
            check("ac_msb_strobe", m_strobe, 1'b1);
            check("ac_msb_done",   m_done,   1'b0);
            check("ac_msb_busy",   m_busy,   1'b1);
            check("ac_msb_ready",  m_ready,  1'b0);
            tick();
        end
        // N+9: DONE
        check("ac_done_msb",   m_done,   1'b1);
        check("ac_done_lsb",   l_done,   1'b1);
        check("ac_done_data",  m_data,   1'b0);
        check("ac_done_ready", m_ready,  1'b0);
        check("ac_done_busy",  m_busy,   1'b1);
        check("ac_done_strb",  m_strobe, 1'b0);
`ifdef PISO_STREAM_CAPTURE_EN
        check("ac_cap_msb", m_cap, 8'hAC);
        check("ac_cap_lsb", l_cap, 8'hAC);
`endif
        tick();                                 // N+10
        check("ac_idle_done",  m_done,  1'b0);
        check("ac_idle_ready", m_ready, 1'b1);
        check("ac_idle_busy",  m_busy,  1'b0);
`ifdef PISO_STREAM_CAPTURE_EN
        check("ac_cap_hold", m_cap, 8'hAC);
`endif

        // 8'hAC with CLK_DIV=3
        data_in = 8'hAC;
        valid_d = 1'b1;
        tick();                                 // N+1
        valid_d = 1'b0;
        strobes = 0;
        for (int t = 1; t <= 24; t++) begin
            check("div3_bit",    d_data,   seq_msb_ac[7-(t-1)/3]);
            check("div3_strobe", d_strobe, (t % 3 == 0) ? 1'b1 : 1'b0);
            check("div3_done",   d_done,   1'b0);
            if (d_strobe === 1'b1) strobes++;
            tick();
        end
        // N+25
        check("div3_strobe_count", strobes, 8);
        check("div3_done_pulse",   d_done,  1'b1);
        check("div3_done_data",    d_data,  1'b0);
`ifdef PISO_STREAM_CAPTURE_EN
        check("div3_cap", d_cap, 8'hAC);
`endif
        tick();
        check("div3_ready", d_ready, 1'b1);

        // Reset after bit 3 is driven, then a clean 8'h55 transfer
        data_in = 8'hAC;
        valid_a = 1'b1;
        tick();                                 // N+1
        valid_a = 1'b0;
        tick();
        tick();
        tick();                                 // N+4, bit 3
        check("abort_bit3", m_data, seq_msb_ac[4]);
        reset_in = 1'b1;
        tick();
        check("abort_data",   m_data,   1'b0);
        check("abort_ready",  m_ready,  1'b1);
        check("abort_busy",   m_busy,   1'b0);
        check("abort_done",   m_done,   1'b0);
        check("abort_strobe", m_strobe, 1'b0);
        reset_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("abort_no_done_msb", m_done, 1'b0);
            check("abort_no_done_lsb", l_done, 1'b0);
            tick();
        end
        data_in = 8'h55;
        valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("x55_msb_bit", m_data, seq_msb_55[7-k]);
            check("x55_lsb_bit", l_data, seq_lsb_55[7-k]);
            tick();
        end
        check("x55_done", m_done, 1'b1);
`ifdef PISO_STREAM_CAPTURE_EN
        check("x55_cap_msb", m_cap, 8'h55);
        check("x55_cap_lsb", l_cap, 8'h55);
`endif
        tick();

        // valid held high, data toggling during SHIFT of 8'hAC
        data_in = 8'hAC;
        valid_a = 1'b1;
        tick();                                 // N+1
        for (int k = 0; k < 8; k++) begin
            data_in = (k % 2 == 0) ? 8'hFF : 8'h00;
            check("hold_bit",   m_data,  seq_msb_ac[7-k]);
            check("hold_ready", m_ready, 1'b0);
            tick();
        end
        // N+9: DONE, still not ready
        check("hold_done",       m_done,  1'b1);
        check("hold_done_ready", m_ready, 1'b0);
        data_in = 8'hC3;
        tick();                                 // N+10: accepted here
        check("hold_accept_ready", m_ready, 1'b1);
        tick();                                 // N+11
        valid_a = 1'b0;
        check("hold_next_busy", m_busy, 1'b1);
        check("hold_next_lsb0", l_data, 1'b1);
        for (int k = 0; k < 8; k++) begin
            check("c3_msb_bit", m_data, seq_msb_c3[7-k]);
            tick();
        end
        check("c3_done", m_done, 1'b1);
`ifdef PISO_STREAM_CAPTURE_EN
        check("c3_cap_msb", m_cap, 8'hC3);
        check("c3_cap_lsb", l_cap, 8'hC3);
`endif
        tick();
        check("c3_ready", m_ready, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
